// File: rtl/trisc_pkg.sv
// Shared widths, opcode encodings and decode-field slices for the TRISC datapath.
package trisc_pkg;

    localparam int AW_DEF = 5;
    localparam int DW_DEF = 8;

    // Opcode field is the top OPC_W bits of IR; operand address is the low AW bits.
    localparam int OPC_W = 3;

    localparam logic [OPC_W-1:0] OP_NOP  = 3'b000;
    localparam logic [OPC_W-1:0] OP_INC  = 3'b001;
    localparam logic [OPC_W-1:0] OP_CLR  = 3'b010;
    localparam logic [OPC_W-1:0] OP_JMP  = 3'b011;
    localparam logic [OPC_W-1:0] OP_LDA  = 3'b100;
    localparam logic [OPC_W-1:0] OP_STA  = 3'b101;
    localparam logic [OPC_W-1:0] OP_ADD  = 3'b110;
    localparam logic [OPC_W-1:0] OP_NOP7 = 3'b111;

endpackage

// File: rtl/trisc_mem32x8.sv
// Program/data RAM: synchronous write, registered read into MDR.
// Host load port owns the write path while the machine is held in reset.
module trisc_mem32x8
    import trisc_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [DW-1:0] load_data,
    input  logic          rd,
    input  logic          wr,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // Contents survive reset; reset only selects which port may write.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (load_en) begin
                mem[load_addr] <= load_data;
            end
        end else if (wr) begin
            mem[addr] <= wdata;
        end
    end

    // Non-blocking read returns pre-write data when rd and wr coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (rd) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/trisc_datapath.sv
// TRISC datapath: PC, address mux, RAM/MDR, IR, DR, ACC, pass/add ALU and opcode decode.
// Optional carry flag is built when TRISC_CARRY_FLAG_EN is defined.
module trisc_datapath
    import trisc_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          SysClock,
    input  logic          Reset,
    input  logic          C0,
    input  logic          C1,
    input  logic          C2,
    input  logic          C3,
    input  logic          C4,
    input  logic          C5,
    input  logic          C7,
    input  logic          C8,
    input  logic          C9,
    input  logic          C10,
    input  logic          C11,
    input  logic          C13,
    input  logic          C14,
    input  logic          LoadEn,
    input  logic [AW-1:0] LoadAddr,
    input  logic [DW-1:0] LoadData,
    output logic          INC,
    output logic          CLR,
    output logic          JMP,
    output logic          LDA,
    output logic          STA,
    output logic          ADD,
`ifdef TRISC_CARRY_FLAG_EN
    output logic          Carry,
`endif
    output logic [AW-1:0] PC,
    output logic [DW-1:0] ACC,
    output logic [DW-1:0] IR
);

    logic [AW-1:0]    addr;
    logic [DW-1:0]    mdr;
    logic [DW-1:0]    dr;
    logic [DW-1:0]    alu;
    logic             add_arm;
    logic [DW:0]      inc_sum;
    logic [DW:0]      add_sum;
    logic [OPC_W-1:0] opcode;
    logic             unused_rsvd;

    assign unused_rsvd = C13;

    assign addr    = C3 ? IR[AW-1:0] : PC;
    assign inc_sum = {1'b0, ACC} + {{DW{1'b0}}, 1'b1};
    assign add_sum = {1'b0, ACC} + {1'b0, dr};
    assign alu     = add_arm ? add_sum[DW-1:0] : dr;
    assign opcode  = IR[DW-1 -: OPC_W];

    trisc_mem32x8 #(.AW(AW), .DW(DW)) u_mem (
        .clk       (SysClock),
        .rst       (Reset),
        .load_en   (LoadEn),
        .load_addr (LoadAddr),
        .load_data (LoadData),
        .rd        (C4),
        .wr        (C5),
        .addr      (addr),
        .wdata     (ACC),
        .rdata     (mdr)
    );

    always_ff @(posedge SysClock) begin
        if (Reset) begin
            PC      <= '0;
            IR      <= '0;
            dr      <= '0;
            ACC     <= '0;
            add_arm <= 1'b0;
        end else begin
            if (C0) begin
                PC <= '0;
            end else if (C1) begin
                PC <= IR[AW-1:0];
            end else if (C2) begin
                PC <= PC + {{(AW-1){1'b0}}, 1'b1};
            end

            if (C7) begin
                IR <= mdr;
            end
            if (C10) begin
                dr <= mdr;
            end

            if (C8) begin
                ACC <= '0;
            end else if (C9) begin
                ACC <= inc_sum[DW-1:0];
            end else if (C11) begin
                ACC <= alu;
            end

            // Arming wins over the C11 disarm so a same-cycle C14 stays armed.
            if (C14) begin
                add_arm <= 1'b1;
            end else if (C11) begin
                add_arm <= 1'b0;
            end
        end
    end

`ifdef TRISC_CARRY_FLAG_EN
    // Follows the same C8 > C9 > C11 priority as ACC so it tracks the value loaded.
    always_ff @(posedge SysClock) begin
        if (Reset) begin
            Carry <= 1'b0;
        end else if (C8) begin
            Carry <= 1'b0;
        end else if (C9) begin
            Carry <= inc_sum[DW];
        end else if (C11) begin
            Carry <= add_arm ? add_sum[DW] : 1'b0;
        end
    end
`endif

    always_comb begin
        INC = 1'b0;
        CLR = 1'b0;
        JMP = 1'b0;
        LDA = 1'b0;
        STA = 1'b0;
        ADD = 1'b0;
        case (opcode)
            OP_INC:  INC = 1'b1;
            OP_CLR:  CLR = 1'b1;
            OP_JMP:  JMP = 1'b1;
            OP_LDA:  LDA = 1'b1;
            OP_STA:  STA = 1'b1;
            OP_ADD:  ADD = 1'b1;
            OP_NOP, OP_NOP7: ;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_trisc_datapath.sv
// Bench for trisc_datapath: acts as the control FSM and checks against an instruction-level model.
// Carry is connected and checked when TRISC_CARRY_FLAG_EN is defined.
module tb_trisc_datapath;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] c = '0;
    logic        ld_en = 1'b0;
    logic [4:0]  ld_addr = '0;
    logic [7:0]  ld_data = '0;
    logic        inc_o, clr_o, jmp_o, lda_o, sta_o, add_o;
    logic [4:0]  pc_o;
    logic [7:0]  acc_o, ir_o;
`ifdef TRISC_CARRY_FLAG_EN
    logic        carry_o;
`endif

    // strobe vector bit positions
    localparam logic [12:0] S_C0  = 13'd1 << 0;
    localparam logic [12:0] S_C1  = 13'd1 << 1;
    localparam logic [12:0] S_C2  = 13'd1 << 2;
    localparam logic [12:0] S_C3  = 13'd1 << 3;
    localparam logic [12:0] S_C4  = 13'd1 << 4;
    localparam logic [12:0] S_C5  = 13'd1 << 5;
    localparam logic [12:0] S_C7  = 13'd1 << 6;
    localparam logic [12:0] S_C8  = 13'd1 << 7;
    localparam logic [12:0] S_C9  = 13'd1 << 8;
    localparam logic [12:0] S_C10 = 13'd1 << 9;
    localparam logic [12:0] S_C11 = 13'd1 << 10;
    localparam logic [12:0] S_C13 = 13'd1 << 11;
    localparam logic [12:0] S_C14 = 13'd1 << 12;

    trisc_datapath dut (
        .SysClock (clk),
        .Reset    (rst),
        .C0       (c[0]),
        .C1       (c[1]),
        .C2       (c[2]),
        .C3       (c[3]),
        .C4       (c[4]),
        .C5       (c[5]),
        .C7       (c[6]),
        .C8       (c[7]),
        .C9       (c[8]),
        .C10      (c[9]),
        .C11      (c[10]),
        .C13      (c[11]),
        .C14      (c[12]),
        .LoadEn   (ld_en),
        .LoadAddr (ld_addr),
        .LoadData (ld_data),
        .INC      (inc_o),
        .CLR      (clr_o),
        .JMP      (jmp_o),
        .LDA      (lda_o),
        .STA      (sta_o),
        .ADD      (add_o),
`ifdef TRISC_CARRY_FLAG_EN
        .Carry    (carry_o),
`endif
        .PC       (pc_o),
        .ACC      (acc_o),
        .IR       (ir_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instruction-level reference model
    int         m_pc;
    int         m_acc;
    int         m_carry;
    logic [7:0] m_ir;
    logic [7:0] m_mem [32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] dec_exp(input logic [7:0] instr);
        int op;
        op = int'(instr) / 32;
        case (op)
            1: return 6'b100000;
            2: return 6'b010000;
            3: return 6'b001000;
            4: return 6'b000100;
            5: return 6'b000010;
            6: return 6'b000001;
            default: return 6'b000000;
        endcase
    endfunction

    task automatic cyc(input logic [12:0] s);
        @(negedge clk);
        c = s;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pc = 0;
        m_acc = 0;
        m_carry = 0;
        m_ir = 8'h00;
    endtask

    task automatic enter_reset();
        @(negedge clk);
        rst = 1'b1;
        c = '0;
        ld_en = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic load(input int a, input logic [7:0] d);
        @(negedge clk);
        c = '0;
        ld_en = 1'b1;
        ld_addr = a[4:0];
        ld_data = d;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
        m_mem[a] = d;
    endtask

    task automatic leave_reset();
        @(negedge clk);
        rst = 1'b0;
        c = '0;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_pc"}, 32'(pc_o), 0);
        chk({tag, "_ir"}, 32'(ir_o), 0);
        chk({tag, "_acc"}, 32'(acc_o), 0);
        chk({tag, "_dec"}, 32'({inc_o, clr_o, jmp_o, lda_o, sta_o, add_o}), 0);
`ifdef TRISC_CARRY_FLAG_EN
        chk({tag, "_carry"}, 32'(carry_o), 0);
`endif
    endtask

    task automatic fetch();
        cyc(S_C4);
        cyc(S_C4);
        cyc(S_C2 | S_C7);
        m_ir = m_mem[m_pc];
        m_pc = (m_pc + 1) % 32;
        chk("fetch_ir", 32'(ir_o), 32'(m_ir));
        chk("fetch_pc", 32'(pc_o), 32'(m_pc));
        chk("decode", 32'({inc_o, clr_o, jmp_o, lda_o, sta_o, add_o}), 32'(dec_exp(m_ir)));
    endtask

    task automatic execute();
        int a;
        int op;
        int sum;
        a = int'(m_ir) % 32;
        op = int'(m_ir) / 32;
        case (op)
            1: begin
                cyc(S_C9);
                m_carry = (m_acc == 255) ? 1 : 0;
                m_acc = (m_acc + 1) % 256;
            end
            2: begin
                cyc(S_C8);
                m_acc = 0;
                m_carry = 0;
            end
            3: begin
                cyc(S_C1);
                m_pc = a;
            end
            4: begin
                cyc(S_C3);
                cyc(S_C3 | S_C4);
                cyc(S_C3 | S_C4 | S_C10);
                cyc(S_C10 | S_C11);
                m_acc = int'(m_mem[a]);
                m_carry = 0;
            end
            5: begin
                cyc(S_C3);
                cyc(S_C3 | S_C4 | S_C5);
                cyc(S_C3 | S_C4 | S_C5);
                m_mem[a] = 8'(m_acc);
            end
            6: begin
                cyc(S_C3);
                cyc(S_C3 | S_C4);
                cyc(S_C3 | S_C4);
                cyc(S_C10);
                cyc(S_C14 | S_C13);
                cyc(S_C11);
                sum = m_acc + int'(m_mem[a]);
                m_carry = (sum > 255) ? 1 : 0;
                m_acc = sum % 256;
            end
            default: ;
        endcase
        chk("exec_acc", 32'(acc_o), 32'(m_acc));
        chk("exec_pc", 32'(pc_o), 32'(m_pc));
`ifdef TRISC_CARRY_FLAG_EN
        chk("exec_carry", 32'(carry_o), 32'(m_carry));
`endif
    endtask

    task automatic run_instr();
        fetch();
        execute();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();

        // Directed program: INC, LDA 7, INC (wrap), LDA 5, JMP 10, ADD 6 (wrap), JMP 31
        enter_reset();
        load(0, 8'h21);
        load(1, 8'h87);
        load(2, 8'h21);
        load(3, 8'h85);
        load(4, 8'h6A);
        load(5, 8'h3C);
        load(6, 8'hD0);
        load(7, 8'hFF);
        load(10, 8'hC6);
        load(11, 8'h7F);
        check_cleared("reset");
        leave_reset();

        run_instr();
        chk("first_inc_line", 32'(inc_o), 1);
        repeat (6) run_instr();
        chk("jmp31_pc", 32'(pc_o), 31);

        cyc(S_C2);
        chk("pc_wrap", 32'(pc_o), 0);
        cyc(S_C2);
        chk("pc_inc", 32'(pc_o), 1);
        cyc(S_C0 | S_C2);
        chk("pc_clr_prio", 32'(pc_o), 0);
        m_pc = 0;

        // STA aborted by reset after the first write strobe
        enter_reset();
        load(0, 8'h88);
        load(1, 8'hA9);
        load(8, 8'hA5);
        leave_reset();
        run_instr();
        fetch();
        cyc(S_C3);
        cyc(S_C3 | S_C4 | S_C5);
        m_mem[9] = 8'(m_acc);
        @(negedge clk);
        rst = 1'b1;
        c = S_C3 | S_C4 | S_C5 | S_C9;
        @(posedge clk);
        #1;
        model_reset();
        check_cleared("abort");
        load(0, 8'h89);
        leave_reset();
        @(negedge clk);
        ld_en = 1'b1;
        ld_addr = 5'd9;
        ld_data = 8'h5A;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
        run_instr();
        chk("sta_retained", 32'(acc_o), 32'h A5);

        // Random programs over the full RAM
        for (int p = 0; p < 3; p++) begin
            enter_reset();
            for (int i = 0; i < 32; i++) begin
                load(i, 8'($urandom));
            end
            leave_reset();
            repeat (60) run_instr();
        end

        @(negedge clk);
        c = '0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
